// File: rtl/mem_load_return.sv
// mem_load_return: single-outstanding load unit for the MEM/WB stage.
// Issues a word-aligned dcache read, formats the byte/half/word result and
// holds it for writeback until the pipeline takes it.
//
// Ports:
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   req_valid/ready     load request handshake
//   req_funct3          RV32 load funct3 (LB/LH/LW/LBU/LHU; others act as LW)
//   req_addr, req_rd    byte address and destination register tag
//   dcache_re/addr      one-cycle read strobe and word-aligned address
//   dcache_resp_valid   dcache_dout valid this cycle
//   dcache_dout         read word
//   wb_valid/ready      writeback handshake
//   wb_data, wb_rd      formatted load data and destination tag
//   wb_err              timeout or misaligned access; wb_data is 0
//   busy                a load is in flight or being held
//
// Optional feature macro: LOAD_MISALIGN_TRAP_EN
//   When defined, misaligned LH/LHU/LW complete with wb_err=1 and no dcache read.
module mem_load_return #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [4:0]        req_rd,
    output logic              dcache_re,
    output logic [DATA_W-1:0] dcache_addr,
    input  logic              dcache_resp_valid,
    input  logic [DATA_W-1:0] dcache_dout,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_err,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic [2:0]        lat_f3;
    logic [1:0]        lat_lsb;
    logic [4:0]        lat_rd;
    logic              accept;
    logic              misalign;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] fmt_data;

    // Read address is always the containing word; lane select happens on return.
    assign dcache_addr = {req_addr[DATA_W-1:2], 2'b00};

    assign cnt_inc = cnt + CNT_W'(1);
    // cnt holds the number of WAIT cycles already elapsed, so the check uses
    // the incremented value: the last allowed WAIT cycle is the one that trips.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL);

`ifdef LOAD_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (req_funct3)
            3'b001, 3'b101: misalign = req_addr[0];
            3'b010:         misalign = (req_addr[1:0] != 2'b00);
            default:        misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        dcache_re = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_WAIT: begin
                if (dcache_resp_valid || timeout_hit) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                req_ready = wb_ready;
                if (wb_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        accept = req_valid & req_ready;
        if (accept) begin
            dcache_re = ~misalign;
            state_nxt = misalign ? S_HOLD : S_WAIT;
        end
        // Keep every handshake output quiet while reset is held.
        if (!reset_n) begin
            state_nxt = S_IDLE;
            req_ready = 1'b0;
            accept    = 1'b0;
            dcache_re = 1'b0;
        end
    end

    assign wb_valid = reset_n & (state == S_HOLD);
    assign busy     = reset_n & (state != S_IDLE);

    always_comb begin
        byte_sel = dcache_dout[{lat_lsb, 3'b000} +: 8];
        half_sel = lat_lsb[1] ? dcache_dout[31:16] : dcache_dout[15:0];
        case (lat_f3)
            3'b000:  fmt_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b001:  fmt_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b100:  fmt_data = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b101:  fmt_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: fmt_data = dcache_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            lat_f3  <= '0;
            lat_lsb <= '0;
            lat_rd  <= '0;
            wb_data <= '0;
            wb_rd   <= '0;
            wb_err  <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                cnt <= cnt_inc;
                if (dcache_resp_valid) begin
                    wb_data <= fmt_data;
                    wb_rd   <= lat_rd;
                    wb_err  <= 1'b0;
                end else if (timeout_hit) begin
                    wb_data <= '0;
                    wb_rd   <= lat_rd;
                    wb_err  <= 1'b1;
                end
            end
            // accept never coincides with WAIT (req_ready is low there)
            if (accept) begin
                cnt     <= '0;
                lat_f3  <= req_funct3;
                lat_lsb <= req_addr[1:0];
                lat_rd  <= req_rd;
                if (misalign) begin
                    wb_data <= '0;
                    wb_rd   <= req_rd;
                    wb_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_load_return.sv
// tb_mem_load_return: directed scoreboard bench for mem_load_return.
// Expected writebacks are queued on accept and compared on wb_valid.
module tb_mem_load_return;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic        dcache_re;
    logic [31:0] dcache_addr;
    logic        dcache_resp_valid;
    logic [31:0] dcache_dout;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;
    logic        busy;

    always #5 clk = ~clk;

    mem_load_return #(
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_rd(req_rd),
        .dcache_re(dcache_re),
        .dcache_addr(dcache_addr),
        .dcache_resp_valid(dcache_resp_valid),
        .dcache_dout(dcache_dout),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_data(wb_data),
        .wb_rd(wb_rd),
        .wb_err(wb_err),
        .busy(busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic err);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_wb_data"}, wb_data, e.data);
            chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
            chk1({tag, "_wb_err"}, wb_err, e.err);
        end
    endtask

    // Accept, respond the next cycle, check at N+2, then retire.
    task automatic simple_load(input string tag, input logic [2:0] f3,
                               input logic [31:0] a, input logic [4:0] rd,
                               input logic [31:0] dout, input logic [31:0] exp_d);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_rd     = rd;
        #1;
        chk1({tag, "_req_ready"}, req_ready, 1'b1);
        chk1({tag, "_dcache_re"}, dcache_re, 1'b1);
        chk({tag, "_dcache_addr"}, dcache_addr, {a[31:2], 2'b00});
        push(exp_d, rd, 1'b0);
        tick;
        req_valid         = 1'b0;
        dcache_resp_valid = 1'b1;
        dcache_dout       = dout;
        #1;
        chk1({tag, "_wait_no_valid"}, wb_valid, 1'b0);
        chk1({tag, "_re_one_cycle"}, dcache_re, 1'b0);
        tick;
        dcache_resp_valid = 1'b0;
        dcache_dout       = '0;
        chk1({tag, "_wb_valid"}, wb_valid, 1'b1);
        sb_check(tag);
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        chk1({tag, "_retired"}, wb_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        req_valid         = 1'b0;
        req_funct3        = '0;
        req_addr          = '0;
        req_rd            = '0;
        dcache_resp_valid = 1'b0;
        dcache_dout       = '0;
        wb_ready          = 1'b0;
        tick;
        tick;
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", 32'(wb_rd), 32'h0);
        chk1("rst_wb_err", wb_err, 1'b0);
        chk1("rst_dcache_re", dcache_re, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick;

        simple_load("lb", 3'b000, 32'h0000_1003, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80);
        simple_load("lhu", 3'b101, 32'h0000_2002, 5'd6, 32'hBEEF_0001, 32'h0000_BEEF);
        simple_load("lh", 3'b001, 32'h0000_2002, 5'd7, 32'hBEEF_0001, 32'hFFFF_BEEF);
        simple_load("lh_lo", 3'b001, 32'h0000_2000, 5'd8, 32'h0001_7FFF, 32'h0000_7FFF);
        simple_load("lbu", 3'b100, 32'h0000_1001, 5'd9, 32'h1234_5678, 32'h0000_0056);
        simple_load("lw", 3'b010, 32'h0000_3008, 5'd10, 32'hCAFE_F00D, 32'hCAFE_F00D);
        simple_load("f3_011", 3'b011, 32'h0000_300C, 5'd11, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Hold with backpressure, then back-to-back retire + accept.
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_3004;
        req_rd     = 5'd9;
        push(32'hDEAD_BEEF, 5'd9, 1'b0);
        tick;
        req_valid         = 1'b0;
        dcache_resp_valid = 1'b1;
        dcache_dout       = 32'hDEAD_BEEF;
        tick;
        dcache_resp_valid = 1'b0;
        dcache_dout       = '0;
        for (int i = 0; i < 5; i++) begin
            chk1("hold_valid", wb_valid, 1'b1);
            chk("hold_data", wb_data, 32'hDEAD_BEEF);
            chk("hold_rd", 32'(wb_rd), 32'd9);
            chk1("hold_req_ready", req_ready, 1'b0);
            tick;
        end
        wb_ready   = 1'b1;
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_4000;
        req_rd     = 5'd3;
        #1;
        chk1("b2b_req_ready", req_ready, 1'b1);
        chk1("b2b_dcache_re", dcache_re, 1'b1);
        sb_check("hold");
        push(32'h0000_007F, 5'd3, 1'b0);
        tick;
        wb_ready          = 1'b0;
        req_valid         = 1'b0;
        dcache_resp_valid = 1'b1;
        dcache_dout       = 32'h0000_007F;
        #1;
        chk1("b2b_wait_valid", wb_valid, 1'b0);
        chk1("b2b_busy", busy, 1'b1);
        tick;
        dcache_resp_valid = 1'b0;
        chk1("b2b_wb_valid", wb_valid, 1'b1);
        sb_check("b2b");
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;

        // Timeout with no response, then a late response is ignored.
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_5000;
        req_rd     = 5'd7;
        push(32'h0, 5'd7, 1'b1);
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk1("to_wait_valid", wb_valid, 1'b0);
            chk1("to_wait_busy", busy, 1'b1);
            tick;
        end
        chk1("to_wb_valid", wb_valid, 1'b1);
        sb_check("timeout");
        dcache_resp_valid = 1'b1;
        dcache_dout       = 32'h1234_5678;
        tick;
        dcache_resp_valid = 1'b0;
        chk1("late_valid", wb_valid, 1'b1);
        chk("late_data", wb_data, 32'h0);
        chk1("late_err", wb_err, 1'b1);
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        chk1("to_idle_busy", busy, 1'b0);

        // Response while idle changes nothing.
        dcache_resp_valid = 1'b1;
        dcache_dout       = 32'h5555_AAAA;
        tick;
        dcache_resp_valid = 1'b0;
        chk1("idle_resp_busy", busy, 1'b0);
        chk1("idle_resp_valid", wb_valid, 1'b0);

        // Reset mid-WAIT drops the load.
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_6000;
        req_rd     = 5'd11;
        tick;
        req_valid = 1'b0;
        chk1("rw_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        tick;
        reset_n           = 1'b1;
        dcache_resp_valid = 1'b1;
        dcache_dout       = 32'hFFFF_FFFF;
        #1;
        chk1("rw_busy", busy, 1'b0);
        chk1("rw_valid", wb_valid, 1'b0);
        chk("rw_data", wb_data, 32'h0);
        chk("rw_rd", 32'(wb_rd), 32'h0);
        chk1("rw_err", wb_err, 1'b0);
        tick;
        dcache_resp_valid = 1'b0;
        chk1("rw_valid_after", wb_valid, 1'b0);
        chk1("rw_busy_after", busy, 1'b0);
        tick;
        chk1("rw_valid_after2", wb_valid, 1'b0);

        // Misaligned LW.
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0011;
        req_rd     = 5'd12;
        #1;
`ifdef LOAD_MISALIGN_TRAP_EN
        chk1("mis_dcache_re", dcache_re, 1'b0);
        chk1("mis_req_ready", req_ready, 1'b1);
        push(32'h0, 5'd12, 1'b1);
        tick;
        req_valid = 1'b0;
        chk1("mis_wb_valid", wb_valid, 1'b1);
        sb_check("mis");
`else
        chk1("mis_dcache_re", dcache_re, 1'b1);
        chk("mis_dcache_addr", dcache_addr, 32'h0000_0010);
        push(32'hA5A5_5A5A, 5'd12, 1'b0);
        tick;
        req_valid         = 1'b0;
        dcache_resp_valid = 1'b1;
        dcache_dout       = 32'hA5A5_5A5A;
        tick;
        dcache_resp_valid = 1'b0;
        chk1("mis_wb_valid", wb_valid, 1'b1);
        sb_check("mis");
`endif
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        chk1("end_busy", busy, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
